// File: rtl/ofm_tx_ctrl_if.sv
// FIFO-side bus of the OFM tx packet mover: ctrl/data show-ahead read ports
// plus the tx MAC FIFO write port. The controller is the master.
interface ofm_tx_ctrl_if;
   logic [33:0] ctrl_fifo_rdata;
   logic        ctrl_fifo_empty;
   logic        ctrl_fifo_rden;
   logic [72:0] data_fifo_rdata;
   logic        data_fifo_empty;
   logic        data_fifo_rden;
   logic [72:0] tx_fifo_wdata;
   logic        tx_fifo_wren;
   logic        tx_fifo_afull;

   modport master (
      input  ctrl_fifo_rdata, ctrl_fifo_empty, data_fifo_rdata, data_fifo_empty, tx_fifo_afull,
      output ctrl_fifo_rden, data_fifo_rden, tx_fifo_wdata, tx_fifo_wren
   );

   modport slave (
      output ctrl_fifo_rdata, ctrl_fifo_empty, data_fifo_rdata, data_fifo_empty, tx_fifo_afull,
      input  ctrl_fifo_rden, data_fifo_rden, tx_fifo_wdata, tx_fifo_wren
   );
endinterface

// File: rtl/ofm_tx_ctrl.sv
// OFM tx packet mover (tx_clk domain). Pops one ctrl word per packet, then
// forwards data words up to tlast into the tx MAC FIFO. Dropped packets are
// consumed silently, runaway packets are truncated with a forced tlast and
// the remainder drained. Byte length is checked against the summed tkeep.
module ofm_tx_ctrl #(
   parameter int C_MAX_WORDS = 1125,
   parameter int C_CNT_W     = 32
) (
   input  logic               tx_clk,
   input  logic               sys_rst,
   ofm_tx_ctrl_if.master      bus,
   output logic               busy,
   output logic [C_CNT_W-1:0] pkt_cnt,
   output logic [C_CNT_W-1:0] drop_cnt,
   output logic [C_CNT_W-1:0] err_cnt
);

   localparam int WC_W = $clog2(C_MAX_WORDS + 1);
   localparam logic [WC_W-1:0] LAST_IDX = WC_W'(C_MAX_WORDS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      XFER  = 2'd1,
      DROP  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t          state;
   state_t          next_state;
   logic            ctrl_rden;
   logic            data_rden;
   logic [15:0]     len;
   logic [15:0]     byte_cnt;
   logic [WC_W-1:0] word_cnt;
   logic [72:0]     wdata;
   logic            wren;

   logic [72:0]     data_word;
   logic            word_last;
   logic [15:0]     byte_sum;
   logic            runaway;
   logic            ctrl_unused;

   // number of valid bytes flagged by a tkeep byte mask
   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'd0, v[i]};
      end
      return n;
   endfunction

   assign data_word   = bus.data_fifo_rdata;
   assign word_last   = data_word[72];
   assign byte_sum    = byte_cnt + 16'(popcount8(data_word[71:64]));
   // word_cnt counts words already moved, so this is the C_MAX_WORDS-th word
   assign runaway     = (word_cnt == LAST_IDX) && !word_last;
   assign ctrl_unused = ^bus.ctrl_fifo_rdata[33:17];

   assign bus.ctrl_fifo_rden = ctrl_rden;
   assign bus.data_fifo_rden = data_rden;
   assign bus.tx_fifo_wdata  = wdata;
   assign bus.tx_fifo_wren   = wren;

   // state register and registered busy flag
   always_ff @(posedge tx_clk) begin
      if (sys_rst) begin
         state <= IDLE;
         busy  <= 1'b0;
      end else begin
         state <= next_state;
         busy  <= (next_state != IDLE);
      end
   end

   // next-state decode
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (ctrl_rden) begin
               next_state = bus.ctrl_fifo_rdata[16] ? DROP : XFER;
            end else begin
               next_state = IDLE;
            end
         end
         XFER: begin
            if (data_rden && word_last) begin
               next_state = IDLE;
            end else if (data_rden && runaway) begin
               next_state = DRAIN;
            end else begin
               next_state = XFER;
            end
         end
         DROP, DRAIN: begin
            if (data_rden && word_last) begin
               next_state = IDLE;
            end else begin
               next_state = state;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // FIFO pop strobes; never asserted on an empty FIFO or during reset
   always_comb begin
      ctrl_rden = 1'b0;
      data_rden = 1'b0;
      if (sys_rst) begin
         ctrl_rden = 1'b0;
         data_rden = 1'b0;
      end else begin
         case (state)
            IDLE:        ctrl_rden = ~bus.ctrl_fifo_empty;
            XFER:        data_rden = ~bus.data_fifo_empty & ~bus.tx_fifo_afull;
            DROP, DRAIN: data_rden = ~bus.data_fifo_empty;
            default: begin
               ctrl_rden = 1'b0;
               data_rden = 1'b0;
            end
         endcase
      end
   end

   // datapath: ctrl latch, tx word register, per-packet and statistics counters
   always_ff @(posedge tx_clk) begin
      if (sys_rst) begin
         len      <= 16'd0;
         byte_cnt <= 16'd0;
         word_cnt <= '0;
         wdata    <= 73'd0;
         wren     <= 1'b0;
         pkt_cnt  <= '0;
         drop_cnt <= '0;
         err_cnt  <= '0;
      end else begin
         wren <= 1'b0;
         if (ctrl_rden) begin
            len      <= bus.ctrl_fifo_rdata[15:0];
            byte_cnt <= 16'd0;
            word_cnt <= '0;
         end else if (state == XFER && data_rden) begin
            wdata    <= {word_last | runaway, data_word[71:0]};
            wren     <= 1'b1;
            byte_cnt <= byte_sum;
            word_cnt <= word_cnt + WC_W'(1);
            if (word_last) begin
               pkt_cnt <= pkt_cnt + C_CNT_W'(1);
               if (byte_sum != len) begin
                  err_cnt <= err_cnt + C_CNT_W'(1);
               end
            end else if (runaway) begin
               pkt_cnt <= pkt_cnt + C_CNT_W'(1);
               err_cnt <= err_cnt + C_CNT_W'(1);
            end
         end
         if (state == DROP && data_rden && word_last) begin
            drop_cnt <= drop_cnt + C_CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_ofm_tx_ctrl.sv
// Bench for ofm_tx_ctrl: FIFO models as queues, a packet-level reference model
// producing the expected tx word stream and counters, table-driven packet
// vectors, hand-written corner sequences and a randomized phase.
module tb_ofm_tx_ctrl;
   localparam int C_MAX = 1125;

   logic        tx_clk = 1'b0;
   logic        sys_rst;
   logic        busy;
   logic [31:0] pkt_cnt, drop_cnt, err_cnt;

   ofm_tx_ctrl_if bus ();

   ofm_tx_ctrl #(.C_MAX_WORDS(C_MAX), .C_CNT_W(32)) dut (
      .tx_clk(tx_clk), .sys_rst(sys_rst), .bus(bus),
      .busy(busy), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .err_cnt(err_cnt)
   );

   always #5 tx_clk = ~tx_clk;

   typedef struct {
      logic [15:0] len;
      logic        drop;
      int          nwords;
      logic [7:0]  last_keep;
      int          exp_wr;
      int          exp_pkt;
      int          exp_drop;
      int          exp_err;
   } vec_t;

   vec_t        vecs[8];
   logic [33:0] ctrl_q[$];
   logic [72:0] data_q[$];
   logic [72:0] exp_q[$];
   logic [72:0] pkt_words[$];

   int total = 0, bad = 0;
   int cyc = 0;
   int m_pkt = 0, m_drop = 0, m_err = 0;
   int wr_obs, dpops, first_cpop, first_dpop, first_wr, last_wr;
   int stall_pct = 0, afull_pct = 0;
   bit afull_force = 1'b0, afull_drv = 1'b0, chk_afull = 1'b0;
   int wr_after_afull;
   int tp = 0, td = 0, te = 0;

   task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic reset_trk();
      wr_obs = 0; dpops = 0;
      first_cpop = -1; first_dpop = -1; first_wr = -1; last_wr = -1;
   endtask

   // one clock: check the registered write, drive FIFO views, capture pops
   task automatic step();
      logic [72:0] w;
      logic        hide;
      @(negedge tx_clk);
      cyc++;
      if (bus.tx_fifo_wren === 1'b1) begin
         wr_obs++;
         if (chk_afull && afull_drv) wr_after_afull++;
         if (first_wr < 0) first_wr = cyc;
         last_wr = cyc;
         if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_tx_write: got %h expected no write", bus.tx_fifo_wdata);
         end else begin
            w = exp_q.pop_front();
            check("tx_word", bus.tx_fifo_wdata, w);
         end
      end
      hide = (stall_pct > 0) && ($urandom_range(99) < stall_pct);
      afull_drv = afull_force || ((afull_pct > 0) && ($urandom_range(99) < afull_pct));
      bus.ctrl_fifo_empty = (ctrl_q.size() == 0);
      bus.ctrl_fifo_rdata = (ctrl_q.size() != 0) ? ctrl_q[0] : 34'd0;
      bus.data_fifo_empty = (data_q.size() == 0) || hide;
      bus.data_fifo_rdata = (data_q.size() != 0) ? data_q[0] : 73'd0;
      bus.tx_fifo_afull   = afull_drv;
      #1;
      if (chk_afull) check("afull_holds_pop", bus.data_fifo_rden, 1'b0);
      if (bus.ctrl_fifo_rden === 1'b1) begin
         check("ctrl_pop_when_empty", bus.ctrl_fifo_empty, 1'b0);
         if (first_cpop < 0) first_cpop = cyc;
         if (ctrl_q.size() != 0) w = 73'(ctrl_q.pop_front());
      end
      if (bus.data_fifo_rden === 1'b1) begin
         check("data_pop_when_empty", bus.data_fifo_empty, 1'b0);
         dpops++;
         if (first_dpop < 0) first_dpop = cyc;
         if (data_q.size() != 0) w = data_q.pop_front();
      end
   endtask

   task automatic build_pkt(input int n, input logic [7:0] last_keep, input bit rand_keep);
      logic [7:0] k;
      for (int i = 0; i < n; i++) begin
         k = (i == n - 1) ? last_keep : (rand_keep ? 8'($urandom_range(255)) : 8'hFF);
         pkt_words.push_back({(i == n - 1) ? 1'b1 : 1'b0, k, $urandom, $urandom});
      end
   endtask

   // reference model: expected tx stream and counters for one whole packet
   task automatic commit_pkt(input logic [15:0] len, input logic drop);
      logic [72:0] w;
      logic [15:0] sum;
      bit          hit_last;
      ctrl_q.push_back({17'd0, drop, len});
      foreach (pkt_words[i]) data_q.push_back(pkt_words[i]);
      if (drop) begin
         m_drop++;
      end else begin
         sum = 16'd0; hit_last = 1'b0;
         for (int i = 0; i < pkt_words.size() && i < C_MAX && !hit_last; i++) begin
            w = pkt_words[i];
            sum = sum + 16'($countones(w[71:64]));
            if (w[72]) hit_last = 1'b1;
            else if (i == C_MAX - 1) w[72] = 1'b1;
            exp_q.push_back(w);
         end
         m_pkt++;
         if (!hit_last || sum != len) m_err++;
      end
      pkt_words.delete();
   endtask

   task automatic drain(input int budget);
      int k;
      k = 0;
      while (!(ctrl_q.size() == 0 && data_q.size() == 0 && busy == 1'b0) && k < budget) begin
         step();
         k++;
      end
      total++;
      if (k >= budget) begin
         bad++;
         $display("FAIL drain_timeout: got %0d cycles required < %0d", k, budget);
      end
      repeat (3) step();
      check("exp_q_empty", exp_q.size(), 73'd0);
   endtask

   task automatic check_model_cnts(input string tag);
      check({tag, "_pkt_cnt"}, pkt_cnt, m_pkt);
      check({tag, "_drop_cnt"}, drop_cnt, m_drop);
      check({tag, "_err_cnt"}, err_cnt, m_err);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_wren"}, bus.tx_fifo_wren, 1'b0);
      check({tag, "_wdata"}, bus.tx_fifo_wdata, 73'd0);
      check({tag, "_ctrl_rden"}, bus.ctrl_fifo_rden, 1'b0);
      check({tag, "_data_rden"}, bus.data_fifo_rden, 1'b0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_pkt_cnt"}, pkt_cnt, 73'd0);
      check({tag, "_drop_cnt"}, drop_cnt, 73'd0);
      check({tag, "_err_cnt"}, err_cnt, 73'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{16'd64,  1'b0, 8,  8'hFF, 8, 1, 0, 0};
      vecs[1] = '{16'd61,  1'b0, 8,  8'h1F, 8, 1, 0, 0};
      vecs[2] = '{16'd60,  1'b0, 8,  8'h1F, 8, 1, 0, 1};
      vecs[3] = '{16'd128, 1'b1, 16, 8'hFF, 0, 0, 1, 0};
      vecs[4] = '{16'd16,  1'b0, 2,  8'hFF, 2, 1, 0, 0};
      vecs[5] = '{16'd0,   1'b0, 1,  8'h00, 1, 1, 0, 0};
      vecs[6] = '{16'd0,   1'b0, 1,  8'h01, 1, 1, 0, 1};
      vecs[7] = '{16'd8,   1'b1, 1,  8'hFF, 0, 0, 1, 0};

      sys_rst = 1'b1;
      bus.ctrl_fifo_empty = 1'b1; bus.ctrl_fifo_rdata = 34'd0;
      bus.data_fifo_empty = 1'b1; bus.data_fifo_rdata = 73'd0;
      bus.tx_fifo_afull   = 1'b0;
      repeat (3) @(negedge tx_clk);
      check_all_zero("reset");
      sys_rst = 1'b0;

      // table-driven packets, each from an idle controller
      for (int i = 0; i < 8; i++) begin
         reset_trk();
         build_pkt(vecs[i].nwords, vecs[i].last_keep, 1'b0);
         commit_pkt(vecs[i].len, vecs[i].drop);
         drain(200);
         tp += vecs[i].exp_pkt; td += vecs[i].exp_drop; te += vecs[i].exp_err;
         check("vec_writes", wr_obs, vecs[i].exp_wr);
         check("vec_data_pops", dpops, vecs[i].nwords);
         check("vec_pkt_cnt", pkt_cnt, tp);
         check("vec_drop_cnt", drop_cnt, td);
         check("vec_err_cnt", err_cnt, te);
         check("vec_first_data_pop", first_dpop, first_cpop + 1);
         if (!vecs[i].drop) begin
            check("vec_first_write", first_wr, first_cpop + 2);
            check("vec_burst_len", last_wr - first_wr, vecs[i].nwords - 1);
         end
      end

      // backpressure held for 20 cycles mid-packet
      reset_trk();
      build_pkt(24, 8'hFF, 1'b0);
      commit_pkt(16'd192, 1'b0);
      repeat (5) step();
      afull_force = 1'b1; chk_afull = 1'b1; wr_after_afull = 0;
      repeat (20) step();
      afull_force = 1'b0; chk_afull = 1'b0;
      check("afull_writes_after_rise_le1", (wr_after_afull <= 1), 1'b1);
      drain(200);
      check("afull_total_writes", wr_obs, 24);
      check_model_cnts("afull");

      // runaway packet truncated, tail drained, next packet intact
      reset_trk();
      build_pkt(C_MAX + 10, 8'hFF, 1'b0);
      commit_pkt(16'd9000, 1'b0);
      build_pkt(3, 8'h0F, 1'b0);
      commit_pkt(16'd20, 1'b0);
      drain(4000);
      check("runaway_writes", wr_obs, C_MAX + 3);
      check("runaway_data_pops", dpops, C_MAX + 13);
      check_model_cnts("runaway");

      // randomized traffic against the reference model
      stall_pct = 20; afull_pct = 25;
      for (int p = 0; p < 40; p++) begin
         int          n;
         logic [15:0] s;
         n = $urandom_range(12, 1);
         build_pkt(n, 8'($urandom_range(255)), 1'b1);
         s = 16'd0;
         foreach (pkt_words[j]) s = s + 16'($countones(pkt_words[j][71:64]));
         if ($urandom_range(1) == 0) s = 16'($urandom_range(200));
         commit_pkt(s, ($urandom_range(4) == 0));
      end
      drain(5000);
      check_model_cnts("random");
      stall_pct = 0; afull_pct = 0;

      // synchronous reset in the middle of a transfer
      build_pkt(20, 8'hFF, 1'b0);
      commit_pkt(16'd160, 1'b0);
      repeat (6) step();
      @(negedge tx_clk);
      sys_rst = 1'b1;
      ctrl_q.delete(); data_q.delete(); exp_q.delete();
      bus.ctrl_fifo_empty = 1'b1; bus.data_fifo_empty = 1'b1; bus.tx_fifo_afull = 1'b0;
      @(negedge tx_clk);
      sys_rst = 1'b0;
      m_pkt = 0; m_drop = 0; m_err = 0;
      #1;
      check_all_zero("midreset");
      build_pkt(4, 8'hFF, 1'b0);
      commit_pkt(16'd32, 1'b0);
      drain(200);
      check_model_cnts("after_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
